// File: rtl/generic_fifo_rd_stream.sv
// generic_fifo_rd_stream
// Read-side drain engine for the 2prf-based generic FIFO envelope. It issues
// read strobes, absorbs the one-cycle register-file read latency in a 2-entry
// output buffer, and presents the words as a bubble-free valid/ready stream.
//
// Ports:
//   clk          single rising-edge clock
//   reset        synchronous, active-high reset
//   flush        one-cycle pulse: drop buffered/in-flight data, clear the FIFO
//   fifo_empty   empty indicator from the FIFO envelope
//   fifo_rd_op   read strobe to the FIFO envelope (combinational)
//   fifo_rd_data FIFO read data, valid one cycle after fifo_rd_op
//   fifo_clr     clear to the FIFO envelope (combinational, = flush unless reset)
//   out_valid    stream data valid
//   out_ready    consumer ready
//   out_data     stream data (head of the output buffer)
//   word_cnt     words delivered since reset/flush, wraps silently
//   busy         buffered or in-flight data exists
module generic_fifo_rd_stream #(
    parameter int unsigned DAT_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_op,
    input  logic [DAT_WIDTH-1:0] fifo_rd_data,
    output logic                 fifo_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DAT_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] word_cnt,
    output logic                 busy
);

    localparam int unsigned OCC_W  = 2;
    localparam int unsigned PEND_W = 3;

    logic [OCC_W-1:0]     occ;
    logic                 infl;
    logic [DAT_WIDTH-1:0] buf0;
    logic [DAT_WIDTH-1:0] buf1;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 fire;
    logic [PEND_W-1:0]    pending;

    // Stream side: head of the buffer, suppressed during a flush cycle.
    assign out_valid = (occ != OCC_W'(0)) && !flush;
    assign out_data  = buf0;
    assign fire      = out_valid && out_ready;

    // Words that will occupy the buffer after this edge if nothing new is issued.
    // fire implies occ>=1, so the subtraction never underflows.
    assign pending    = PEND_W'(occ) + PEND_W'(infl) - PEND_W'(fire);
    assign fifo_rd_op = !reset && !flush && !fifo_empty && (pending < PEND_W'(2));

    // Reset dominates a coincident flush so the envelope is not cleared.
    assign fifo_clr = flush && !reset;

    assign word_cnt = cnt;
    assign busy     = (occ != OCC_W'(0)) || infl;

    // Control state: occupancy, in-flight flag, delivered-word counter.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occ  <= OCC_W'(0);
            infl <= 1'b0;
            cnt  <= CNT_WIDTH'(0);
        end else begin
            infl <= fifo_rd_op;
            if (fire) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
            case ({infl, fire})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Output buffer payload (shift organisation, buf0 is the head); no reset needed.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            case ({infl, fire})
                2'b10: begin
                    if (occ == OCC_W'(0)) begin
                        buf0 <= fifo_rd_data;
                    end else begin
                        buf1 <= fifo_rd_data;
                    end
                end
                2'b01: begin
                    buf0 <= buf1;
                end
                2'b11: begin
                    if (occ == OCC_W'(2)) begin
                        buf0 <= buf1;
                        buf1 <= fifo_rd_data;
                    end else begin
                        buf0 <= fifo_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Structural invariants of the issue rule.
    a_occ_max : assert property (@(posedge clk) disable iff (reset) occ <= OCC_W'(2));
    a_no_ovf  : assert property (@(posedge clk) disable iff (reset)
                                 (occ == OCC_W'(2)) |-> (!fifo_rd_op || fire));
    a_no_empty_rd : assert property (@(posedge clk) fifo_rd_op |-> !fifo_empty);

endmodule

// File: tb/tb_generic_fifo_rd_stream.sv
// Directed testbench for generic_fifo_rd_stream with a behavioural FIFO
// envelope (queue, one-cycle read latency, clear) around the DUT.
module tb_generic_fifo_rd_stream;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          out_ready = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] fifo_rd_data = '0;
    logic [DW-1:0] out_data;
    logic          fifo_rd_op;
    logic          fifo_clr;
    logic          out_valid;
    logic          busy;
    logic [CW-1:0] word_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int rdop_cnt = 0;
    int viol_cnt = 0;

    logic [DW-1:0] fq[$];

    generic_fifo_rd_stream #(.DAT_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_rd_op(fifo_rd_op), .fifo_rd_data(fifo_rd_data), .fifo_clr(fifo_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .word_cnt(word_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // FIFO envelope model: registered read data, clear, write port.
    always @(posedge clk) begin
        if (fifo_clr) begin
            fq.delete();
        end else begin
            if (fifo_rd_op && fq.size() != 0) fifo_rd_data <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Read-strobe bookkeeping.
    always @(posedge clk) begin
        if (fifo_rd_op) rdop_cnt <= rdop_cnt + 1;
        if (fifo_rd_op && fifo_empty) viol_cnt <= viol_cnt + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; flush = 1'b0;
        #1;
        n_cmp++; if (fifo_rd_op !== 1'b0) begin n_fail++; $display("FAIL rst_rdop: got %b want 0", fifo_rd_op); end
        n_cmp++; if (fifo_clr !== 1'b0) begin n_fail++; $display("FAIL rst_clr: got %b want 0", fifo_clr); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (word_cnt !== CW'(0)) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", word_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    endtask

    // 4 words, consumer always ready: exact latency and back-to-back delivery.
    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            out_ready = 1'b1; wr_en = (i < 4); wr_data = 32'hA0 + 32'(i);
            #1;
            n_cmp++;
            if (fifo_rd_op !== (i >= 1 && i <= 4)) begin
                n_fail++; $display("FAIL basic_rdop c%0d: got %b want %b", i, fifo_rd_op, (i >= 1 && i <= 4));
            end
            n_cmp++;
            if (out_valid !== (i >= 3 && i <= 6)) begin
                n_fail++; $display("FAIL basic_valid c%0d: got %b want %b", i, out_valid, (i >= 3 && i <= 6));
            end
            if (i >= 3 && i <= 6) begin
                n_cmp++;
                if (out_data !== 32'hA0 + 32'(i - 3)) begin
                    n_fail++; $display("FAIL basic_data c%0d: got %h want %h", i, out_data, 32'hA0 + 32'(i - 3));
                end
            end
        end
        n_cmp++; if (word_cnt !== CW'(4)) begin n_fail++; $display("FAIL basic_cnt: got %0d want 4", word_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", busy); end
    endtask

    // Consumer stalled: only two reads, head held; then a full-rate drain.
    task automatic test_backpressure();
        int r0;
        do_reset();
        r0 = rdop_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            out_ready = 1'b0; wr_en = 1'b1; wr_data = 32'hB0 + 32'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (fifo_rd_op !== 1'b0) begin n_fail++; $display("FAIL bp_rdop c%0d: got %b want 0", i, fifo_rd_op); end
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d: got %b want 1", i, out_valid); end
            n_cmp++; if (out_data !== 32'hB0) begin n_fail++; $display("FAIL bp_hold c%0d: got %h want b0", i, out_data); end
        end
        n_cmp++; if (rdop_cnt - r0 !== 2) begin n_fail++; $display("FAIL bp_nreads: got %0d want 2", rdop_cnt - r0); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid c%0d: got %b want 1", i, out_valid); end
            n_cmp++;
            if (out_data !== 32'hB0 + 32'(i)) begin
                n_fail++; $display("FAIL drain_data c%0d: got %h want %h", i, out_data, 32'hB0 + 32'(i));
            end
        end
        @(negedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_end_valid: got %b want 0", out_valid); end
        n_cmp++; if (word_cnt !== CW'(10)) begin n_fail++; $display("FAIL drain_cnt: got %0d want 10", word_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_busy: got %b want 0", busy); end
    endtask

    // Toggling ready: no loss, no duplication, order preserved.
    task automatic test_toggle_ready();
        int k = 0;
        int v0;
        do_reset();
        v0 = viol_cnt;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            wr_en = (i < 8); wr_data = 32'hC0 + 32'(i); out_ready = (i % 2 == 0);
            #1;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (k >= 8 || out_data !== 32'hC0 + 32'(k)) begin
                    n_fail++; $display("FAIL tog_data #%0d: got %h want %h", k, out_data, 32'hC0 + 32'(k));
                end
                k++;
            end
        end
        n_cmp++; if (k !== 8) begin n_fail++; $display("FAIL tog_count: got %0d want 8", k); end
        n_cmp++; if (word_cnt !== CW'(8)) begin n_fail++; $display("FAIL tog_cnt: got %0d want 8", word_cnt); end
        n_cmp++; if (viol_cnt !== v0) begin n_fail++; $display("FAIL tog_empty_rd: got %0d want %0d", viol_cnt, v0); end
    endtask

    // Flush while streaming with a read in flight.
    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_ready = 1'b1; wr_en = 1'b1; wr_data = 32'hD0 + 32'(i);
        end
        @(negedge clk);
        wr_en = 1'b0; flush = 1'b1;
        #1;
        n_cmp++; if (fifo_clr !== 1'b1) begin n_fail++; $display("FAIL fl_clr: got %b want 1", fifo_clr); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", out_valid); end
        n_cmp++; if (fifo_rd_op !== 1'b0) begin n_fail++; $display("FAIL fl_rdop: got %b want 0", fifo_rd_op); end
        n_cmp++; if (word_cnt !== CW'(1)) begin n_fail++; $display("FAIL fl_cnt_pre: got %0d want 1", word_cnt); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fl_busy_pre: got %b want 1", busy); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp++; if (word_cnt !== CW'(0)) begin n_fail++; $display("FAIL fl_cnt_post: got %0d want 0", word_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fl_busy_post: got %b want 0", busy); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_stale c%0d: got %b data %h want 0", i, out_valid, out_data); end
        end
    endtask

    // 17 words through a 4-bit counter wrap to 1.
    task automatic test_wrap();
        int k = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            out_ready = 1'b1; wr_en = (i < 17); wr_data = 32'hE0 + 32'(i);
            #1;
            if (out_valid) k++;
        end
        n_cmp++; if (k !== 17) begin n_fail++; $display("FAIL wrap_fires: got %0d want 17", k); end
        n_cmp++; if (word_cnt !== CW'(1)) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 1", word_cnt); end
    endtask

    // Reset and flush together while the buffer is full.
    task automatic test_reset_flush();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wr_en = (i < 5); wr_data = 32'hF0 + 32'(i); out_ready = (i == 6);
        end
        @(negedge clk);
        wr_en = 1'b0; out_ready = 1'b0;
        #1;
        n_cmp++; if (word_cnt !== CW'(1)) begin n_fail++; $display("FAIL rf_cnt_pre: got %0d want 1", word_cnt); end
        n_cmp++; if (out_data !== 32'hF1) begin n_fail++; $display("FAIL rf_head_pre: got %h want f1", out_data); end
        n_cmp++; if (fifo_rd_op !== 1'b0) begin n_fail++; $display("FAIL rf_full_rdop: got %b want 0", fifo_rd_op); end
        @(negedge clk);
        reset = 1'b1; flush = 1'b1;
        #1;
        n_cmp++; if (fifo_clr !== 1'b0) begin n_fail++; $display("FAIL rf_clr: got %b want 0", fifo_clr); end
        n_cmp++; if (fifo_rd_op !== 1'b0) begin n_fail++; $display("FAIL rf_rdop: got %b want 0", fifo_rd_op); end
        @(negedge clk);
        reset = 1'b0; flush = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rf_valid: got %b want 0", out_valid); end
        n_cmp++; if (word_cnt !== CW'(0)) begin n_fail++; $display("FAIL rf_cnt: got %0d want 0", word_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rf_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_toggle_ready();
        test_flush();
        test_wrap();
        test_reset_flush();
        n_cmp++; if (viol_cnt !== 0) begin n_fail++; $display("FAIL empty_read_total: got %0d want 0", viol_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
